// File: rtl/axi_bus_decoder_if.sv
// rtl/axi_bus_decoder_if.sv - cpu request/response bus bundle for the slave-port decoder
interface axi_bus_decoder_if #(
  parameter int NPORTS = 4
);
  // Master (cpu) side
  logic                   m_avalid;
  logic                   m_aready;
  logic                   m_awe;
  logic [29:0]            m_aaddr;
  logic [31:0]            m_adata;
  logic [3:0]             m_astrb;
  logic                   m_bvalid;
  logic [31:0]            m_bdata;
  logic                   m_berr;

  // Slave (peripheral) side
  logic [NPORTS-1:0]      s_avalid;
  logic [NPORTS-1:0]      s_aready;
  logic                   s_awe;
  logic [29:0]            s_aaddr;
  logic [31:0]            s_adata;
  logic [3:0]             s_astrb;
  logic [NPORTS-1:0]      s_bvalid;
  logic [32*NPORTS-1:0]   s_bdata;

  modport master (
    output m_avalid, m_awe, m_aaddr, m_adata, m_astrb,
    input  m_aready, m_bvalid, m_bdata, m_berr
  );

  modport slave (
    input  s_avalid, s_awe, s_aaddr, s_adata, s_astrb,
    output s_aready, s_bvalid, s_bdata
  );

  modport dec (
    input  m_avalid, m_awe, m_aaddr, m_adata, m_astrb,
    output m_aready, m_bvalid, m_bdata, m_berr,
    output s_avalid, s_awe, s_aaddr, s_adata, s_astrb,
    input  s_aready, s_bvalid, s_bdata
  );
endinterface

// File: rtl/axi_bus_decoder.sv
// rtl/axi_bus_decoder.sv - 1-master/NPORTS-slave base/mask decoder with response timeout
module axi_bus_decoder #(
  parameter int                   NPORTS       = 4,
  parameter logic [30*NPORTS-1:0] BASES        = {NPORTS{30'h0}},
  parameter logic [30*NPORTS-1:0] MASKS        = {NPORTS{30'h0}},
  parameter int                   DEFAULT_PORT = NPORTS - 1,
  parameter int                   TIMEOUT      = 1024,
  parameter logic [31:0]          ERR_DATA     = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                rst_n,
  axi_bus_decoder_if.dec      bus,
  output logic                err_flag,
  input  logic                err_clr
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  // A zero TIMEOUT would give a zero-width counter; keep one bit so the logic stays legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR} state_t;

  state_t            state;
  logic [PW-1:0]     cur;
  logic [PW-1:0]     sel;
  logic              hit;
  logic [NPORTS-1:0] orphan;
  logic [CW-1:0]     counter;

  // Address decode: lowest matching port wins, unmatched falls to the default port.
  always_comb begin
    sel = PW'(DEFAULT_PORT);
    hit = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (!hit && ((bus.m_aaddr & MASKS[30*i +: 30]) == BASES[30*i +: 30])) begin
        sel = PW'(i);
        hit = 1'b1;
      end
    end
  end

  // Request routing; an orphaned port is answered locally with an error instead of being asked.
  always_comb begin
    bus.m_aready = 1'b0;
    bus.s_avalid = '0;
    if (rst_n && state == ST_IDLE) begin
      if (orphan[sel]) begin
        bus.m_aready = 1'b1;
      end else begin
        bus.m_aready      = bus.s_aready[sel];
        bus.s_avalid[sel] = bus.m_avalid;
      end
    end
  end

  // Response path: only the port holding the outstanding access is forwarded.
  always_comb begin
    bus.m_bvalid = 1'b0;
    bus.m_bdata  = '0;
    bus.m_berr   = 1'b0;
    case (state)
      ST_WAIT: begin
        bus.m_bvalid = bus.s_bvalid[cur];
        bus.m_bdata  = bus.s_bdata[32*int'(cur) +: 32];
      end
      ST_ERR: begin
        bus.m_bvalid = 1'b1;
        bus.m_bdata  = ERR_DATA;
        bus.m_berr   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.s_awe   = bus.m_awe;
  assign bus.s_aaddr = bus.m_aaddr;
  assign bus.s_adata = bus.m_adata;
  assign bus.s_astrb = bus.m_astrb;

  // Access tracking FSM, timeout counter, orphan bookkeeping and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur      <= '0;
      orphan   <= '0;
      counter  <= '0;
      err_flag <= 1'b0;
    end else begin
      // Any response not being forwarded is a late answer; it releases that port's orphan bit.
      // The current port never has its orphan bit set while in WAIT, so masking it here is safe.
      orphan <= orphan & ~bus.s_bvalid;

      if (state == ST_ERR) begin
        err_flag <= 1'b1;
      end else if (err_clr) begin
        err_flag <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (bus.m_avalid && bus.m_aready) begin
            if (orphan[sel]) begin
              state <= ST_ERR;
            end else begin
              cur     <= sel;
              counter <= '0;
              state   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus.s_bvalid[cur]) begin
            state <= ST_IDLE;
          end else if (TIMEOUT != 0 && counter == CNT_LAST) begin
            orphan[cur] <= 1'b1;
            state       <= ST_ERR;
          end else if (counter != CNT_MAX) begin
            counter <= counter + 1'b1;
          end
        end
        ST_ERR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
